smiley_bounce_arbiter: RTL and testbench
========================================

# smiley_bounce_arbiter

Per-frame collision arbiter between the pixel-rate collision detectors and the smiley motion logic. Collision pulses for the smiley against the top, left and right borders, the flipper and obstacles arrive many times per frame, once per overlapping pixel. This block latches them during the frame and commits exactly one merged bounce command per frame at startOfFrame. It also applies a per-source cooldown so that a smiley still overlapping an object does not re-bounce on every frame.

## Interface
Parameters:
- COOLDOWN_FRAMES, 4: number of commits during which a just-committed source is masked; 0 disables masking. Legal range 0..15.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset, synchronous and active-high despite the name: resetN=1 on a rising clk edge resets the block.
- startOfFrame  in  1  one-cycle frame pulse.
- pause  in  1  level; freezes arbitration.
- reset_level  in  1  pulse; same clearing effect as reset.
- collisionSmileyBorderTop  in  1  pixel-rate collision.
- collisionSmileyBorderLeft  in  1  pixel-rate collision.
- collisionSmileyBorderRight  in  1  pixel-rate collision.
- collisionSmileyFlipper  in  1  pixel-rate collision.
- collisionSmileyObstacle  in  1  pixel-rate collision.
- hitEdgeCode  in  4  smiley edge touched, valid with the obstacle collision: [0] left, [1] top, [2] right, [3] bottom.
- bounceValid  out  1  one-cycle pulse per committed bounce.
- flipX  out  1  invert the X velocity; valid with bounceValid, 0 otherwise.
- flipY  out  1  invert the Y velocity; valid with bounceValid, 0 otherwise.
- bounceSrc  out  5  mask of contributing sources: [0] top, [1] left, [2] right, [3] flipper, [4] obstacle. Valid with bounceValid, 0 otherwise.
- collisionSmileyObstacleReal  out  1  one-cycle scoring pulse; asserted when the obstacle source is committed.

## Operation
- FSM states are IDLE, COLLECT and COMMIT.
  - The reset state is IDLE.
  - In IDLE, collisions are ignored. The first non-paused startOfFrame moves the FSM to COLLECT.
  - In COLLECT, five sticky live latches are set by the collision inputs. On the first obstacle pulse of the frame, hitEdgeCode is captured; later obstacle pulses in the same frame do not overwrite it.
  - On a startOfFrame in COLLECT with pause=0:
    - The live latches and the captured code are copied into snapshot registers.
    - The live latches are cleared; a collision present in this same cycle is latched into the fresh set, for the next frame.
    - The FSM moves to COMMIT.
  - COMMIT lasts one cycle, then the FSM returns to COLLECT.
- Commit evaluation uses the snapshot:
  - Source s is eligible iff its snapshot bit is 1 and cooldown[s]==0.
  - Each eligible source contributes to the flip axes:
    - top sets flipY;
    - left or right sets flipX;
    - flipper sets flipY;
    - obstacle sets flipX = code[0]|code[2] and flipY = code[1]|code[3]. A code of 0 is treated as flipY=1.
  - flipX and flipY are the OR of all contributions, so the same axis is never flipped twice.
  - bounceSrc is the mask of eligible sources. bounceValid=1 iff that mask is non-zero.
  - Latched but ineligible events are discarded silently.
- Cooldown counters are 4 bits each, one per source, updated in the COMMIT cycle:
  - A committed source loads COOLDOWN_FRAMES.
  - Any other non-zero counter decrements by 1.
  - Result: a source committed at commit k is masked for commits k+1 .. k+COOLDOWN_FRAMES.
- pause=1:
  - No commit occurs and startOfFrame is ignored.
  - Live latches are held cleared.
  - Counters and state are frozen.
  - If the FSM is in COMMIT when pause rises, that commit still completes.
- reset_level=1, or resetN=1, in any state, mid-commit included:
  - Next cycle, all latches, snapshots and counters are 0, all outputs are 0, and the state is IDLE.
  - resetN has priority over all other inputs.

## Timing
- All outputs are registered; the reset value of every output is 0.
- startOfFrame is sampled high at cycle t in COLLECT, with pause=0.
- bounceValid, flipX, flipY, bounceSrc and collisionSmileyObstacleReal are asserted during cycle t+1 only. Latency is 1 cycle.
- At most one bounceValid is issued per frame.
- A collision at cycle t counts toward the next frame, not the current one.
- The cooldown decrement is visible to the evaluation at the following commit.

## Test plan
- Reset then startOfFrame; top pulses at 10 cycles; startOfFrame -> one cycle later bounceValid=1, flipY=1, flipX=0, bounceSrc=5'b00001.
- Flipper and obstacle (hitEdgeCode=4'b0001) in the same frame -> flipX=1, flipY=1, bounceSrc=5'b11000, collisionSmileyObstacleReal=1 for one cycle.
- COOLDOWN_FRAMES=4, flipper asserted every frame -> bounceValid on commits 1, 6, 11; no pulse on commits 2-5.
- Left collision in the same cycle as startOfFrame -> no bounce at this commit; bounce with flipX=1 at the next commit.
- pause=1 across two startOfFrames with collisions present -> no outputs, counters unchanged; after pause drops, the first commit reports only post-pause collisions.
- reset_level during COMMIT with cooldowns at 3 -> outputs 0 next cycle, state IDLE; after two frames, a flipper collision bounces immediately.

Source files
------------

// File: rtl/smiley_bounce_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : smiley_bounce_arbiter
// Purpose  : Latches pixel-rate smiley collisions over a frame and commits one
//            merged, cooldown-filtered bounce command per startOfFrame.
// Revision : 1.0 - initial release
// ============================================================================
module smiley_bounce_arbiter #(
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       pause,
  input  logic       reset_level,
  input  logic       collisionSmileyBorderTop,
  input  logic       collisionSmileyBorderLeft,
  input  logic       collisionSmileyBorderRight,
  input  logic       collisionSmileyFlipper,
  input  logic       collisionSmileyObstacle,
  input  logic [3:0] hitEdgeCode,
  output logic       bounceValid,
  output logic       flipX,
  output logic       flipY,
  output logic [4:0] bounceSrc,
  output logic       collisionSmileyObstacleReal
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  localparam logic [3:0] COOL_LOAD = 4'(COOLDOWN_FRAMES);

  state_t          state;
  logic [4:0]      liveSrc;
  logic [3:0]      liveCode;
  logic [4:0][3:0] cooldown;

  logic [4:0] pulseNow;
  logic [4:0] eligible;
  logic [3:0] obsCode;
  logic       evalFlipX;
  logic       evalFlipY;

  assign pulseNow = {collisionSmileyObstacle, collisionSmileyFlipper,
                     collisionSmileyBorderRight, collisionSmileyBorderLeft,
                     collisionSmileyBorderTop};

  // The live latches are evaluated at the startOfFrame edge so the registered
  // result lands exactly one cycle later; the output registers hold the snapshot.
  always_comb begin
    eligible = 5'd0;
    for (int s = 0; s < 5; s++) begin
      eligible[s] = liveSrc[s] && (cooldown[s] == 4'd0);
    end
    obsCode   = (liveCode == 4'd0) ? 4'b0010 : liveCode;
    evalFlipY = eligible[0] | eligible[3] | (eligible[4] & (obsCode[1] | obsCode[3]));
    evalFlipX = eligible[1] | eligible[2] | (eligible[4] & (obsCode[0] | obsCode[2]));
  end

  always_ff @(posedge clk) begin
    if (resetN || reset_level) begin
      state                       <= IDLE;
      liveSrc                     <= 5'd0;
      liveCode                    <= 4'd0;
      cooldown                    <= '0;
      bounceValid                 <= 1'b0;
      flipX                       <= 1'b0;
      flipY                       <= 1'b0;
      bounceSrc                   <= 5'd0;
      collisionSmileyObstacleReal <= 1'b0;
    end else begin
      bounceValid                 <= 1'b0;
      flipX                       <= 1'b0;
      flipY                       <= 1'b0;
      bounceSrc                   <= 5'd0;
      collisionSmileyObstacleReal <= 1'b0;

      case (state)
        IDLE: begin
          if (startOfFrame && !pause) begin
            state <= COLLECT;
          end
        end

        COLLECT: begin
          if (pause) begin
            liveSrc  <= 5'd0;
            liveCode <= 4'd0;
          end else if (startOfFrame) begin
            bounceValid                 <= |eligible;
            flipX                       <= evalFlipX;
            flipY                       <= evalFlipY;
            bounceSrc                   <= eligible;
            collisionSmileyObstacleReal <= eligible[4];
            // Same-cycle collisions seed the next frame.
            liveSrc  <= pulseNow;
            liveCode <= pulseNow[4] ? hitEdgeCode : 4'd0;
            state    <= COMMIT;
          end else begin
            liveSrc <= liveSrc | pulseNow;
            if (pulseNow[4] && !liveSrc[4]) begin
              liveCode <= hitEdgeCode;
            end
          end
        end

        COMMIT: begin
          for (int s = 0; s < 5; s++) begin
            if (bounceSrc[s]) begin
              cooldown[s] <= COOL_LOAD;
            end else if (cooldown[s] != 4'd0) begin
              cooldown[s] <= cooldown[s] - 4'd1;
            end
          end
          if (pause) begin
            liveSrc  <= 5'd0;
            liveCode <= 4'd0;
          end else begin
            liveSrc <= liveSrc | pulseNow;
            if (pulseNow[4] && !liveSrc[4]) begin
              liveCode <= hitEdgeCode;
            end
          end
          state <= COLLECT;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_smiley_bounce_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_smiley_bounce_arbiter
// Purpose  : Directed scenarios plus randomized traffic against a frame-level
//            reference model of the bounce arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_smiley_bounce_arbiter;

  localparam int CF = 4;

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       pause = 1'b0;
  logic       reset_level = 1'b0;
  logic       cTop = 1'b0, cLeft = 1'b0, cRight = 1'b0, cFlip = 1'b0, cObs = 1'b0;
  logic [3:0] hitEdgeCode = 4'd0;
  logic       bounceValid, flipX, flipY, obsReal;
  logic [4:0] bounceSrc;

  int checks = 0;
  int errors = 0;

  smiley_bounce_arbiter #(.COOLDOWN_FRAMES(CF)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pause(pause),
    .reset_level(reset_level),
    .collisionSmileyBorderTop(cTop), .collisionSmileyBorderLeft(cLeft),
    .collisionSmileyBorderRight(cRight), .collisionSmileyFlipper(cFlip),
    .collisionSmileyObstacle(cObs), .hitEdgeCode(hitEdgeCode),
    .bounceValid(bounceValid), .flipX(flipX), .flipY(flipY),
    .bounceSrc(bounceSrc), .collisionSmileyObstacleReal(obsReal)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: frame bookkeeping with hit counts and per-source cooldown integers.
  bit         mRunning = 0;
  bit         mCommitCycle = 0;
  int         hitCnt[5];
  logic [3:0] firstCode;
  int         cool[5];
  logic [4:0] lastSrc;
  logic       eValid, eX, eY, eObs;
  logic [4:0] eSrc;

  function automatic logic [4:0] hitsNow();
    return {cObs, cFlip, cRight, cLeft, cTop};
  endfunction

  task automatic clearHits();
    for (int s = 0; s < 5; s++) hitCnt[s] = 0;
    firstCode = 4'd0;
  endtask

  task automatic addHits(input logic [4:0] h);
    if (h[4] && hitCnt[4] == 0) firstCode = hitEdgeCode;
    for (int s = 0; s < 5; s++) if (h[s]) hitCnt[s]++;
  endtask

  task automatic modelStep();
    logic [4:0] h;
    h = hitsNow();
    eValid = 0; eX = 0; eY = 0; eSrc = 0; eObs = 0;
    if (resetN || reset_level) begin
      mRunning = 0; mCommitCycle = 0; lastSrc = 0;
      clearHits();
      for (int s = 0; s < 5; s++) cool[s] = 0;
      return;
    end
    if (mCommitCycle) begin
      for (int s = 0; s < 5; s++)
        cool[s] = lastSrc[s] ? CF : ((cool[s] > 0) ? cool[s] - 1 : 0);
      mCommitCycle = 0;
      if (pause) clearHits(); else addHits(h);
    end else if (!mRunning) begin
      if (startOfFrame && !pause) mRunning = 1;
    end else if (pause) begin
      clearHits();
    end else if (startOfFrame) begin
      for (int s = 0; s < 5; s++) eSrc[s] = (hitCnt[s] > 0) && (cool[s] == 0);
      eValid = (eSrc != 0);
      eObs   = eSrc[4];
      eY = eSrc[0] || eSrc[3] ||
           (eSrc[4] && (firstCode == 0 || firstCode[1] || firstCode[3]));
      eX = eSrc[1] || eSrc[2] || (eSrc[4] && (firstCode[0] || firstCode[2]));
      lastSrc = eSrc;
      mCommitCycle = 1;
      clearHits();
      addHits(h);
    end else begin
      addHits(h);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkValue("mValid", 16'(bounceValid), 16'(eValid));
    checkValue("mFlipX", 16'(flipX), 16'(eX));
    checkValue("mFlipY", 16'(flipY), 16'(eY));
    checkValue("mSrc", 16'(bounceSrc), 16'(eSrc));
    checkValue("mObsReal", 16'(obsReal), 16'(eObs));
  endtask

  task automatic setHits(input logic [4:0] h);
    {cObs, cFlip, cRight, cLeft, cTop} = h;
  endtask

  // Collisions on two mid-frame cycles, then a startOfFrame carrying sofHits.
  task automatic frame(input logic [4:0] hits, input logic [4:0] sofHits,
                       input logic [3:0] code, input int len);
    hitEdgeCode = code;
    for (int i = 0; i < len; i++) begin
      setHits((i == 2 || i == 3) ? hits : 5'd0);
      startOfFrame = 0;
      tick();
    end
    setHits(sofHits);
    startOfFrame = 1;
    tick();
    startOfFrame = 0;
    setHits(5'd0);
  endtask

  initial begin
    clearHits();
    for (int s = 0; s < 5; s++) cool[s] = 0;
    lastSrc = 0;

    resetN = 1; tick(); tick(); resetN = 0;
    checkValue("rstValid", 16'(bounceValid), 16'd0);
    checkValue("rstSrc", 16'(bounceSrc), 16'd0);

    frame(5'd0, 5'd0, 4'd0, 4);
    frame(5'b00001, 5'd0, 4'd0, 10);
    checkValue("topValid", 16'(bounceValid), 16'd1);
    checkValue("topFlipY", 16'(flipY), 16'd1);
    checkValue("topFlipX", 16'(flipX), 16'd0);
    checkValue("topSrc", 16'(bounceSrc), 16'h01);

    frame(5'b11000, 5'd0, 4'b0001, 8);
    checkValue("fobFlipX", 16'(flipX), 16'd1);
    checkValue("fobFlipY", 16'(flipY), 16'd1);
    checkValue("fobSrc", 16'(bounceSrc), 16'h18);
    checkValue("fobObsReal", 16'(obsReal), 16'd1);
    tick();
    checkValue("obsRealPulse", 16'(obsReal), 16'd0);

    resetN = 1; tick(); resetN = 0;
    frame(5'd0, 5'd0, 4'd0, 4);
    for (int k = 1; k <= 11; k++) begin
      frame(5'b01000, 5'd0, 4'd0, 6);
      checkValue($sformatf("cool%0d", k), 16'(bounceValid),
                 16'((k == 1 || k == 6 || k == 11) ? 1 : 0));
    end

    frame(5'd0, 5'b00010, 4'd0, 6);
    checkValue("leftSameSof", 16'(bounceValid), 16'd0);
    frame(5'd0, 5'd0, 4'd0, 6);
    checkValue("leftNextValid", 16'(bounceValid), 16'd1);
    checkValue("leftNextFlipX", 16'(flipX), 16'd1);
    checkValue("leftNextSrc", 16'(bounceSrc), 16'h02);

    pause = 1;
    frame(5'b00001, 5'd0, 4'd0, 6);
    checkValue("pause1", 16'(bounceValid), 16'd0);
    frame(5'b00001, 5'd0, 4'd0, 6);
    checkValue("pause2", 16'(bounceValid), 16'd0);
    pause = 0;
    frame(5'b00100, 5'd0, 4'd0, 6);
    checkValue("postPauseSrc", 16'(bounceSrc), 16'h04);

    frame(5'b01001, 5'd0, 4'd0, 6);
    reset_level = 1; tick(); reset_level = 0;
    checkValue("rlValid", 16'(bounceValid), 16'd0);
    checkValue("rlSrc", 16'(bounceSrc), 16'd0);
    frame(5'b01001, 5'd0, 4'd0, 6);
    checkValue("rlIdleIgnore", 16'(bounceValid), 16'd0);
    frame(5'd0, 5'd0, 4'd0, 6);
    frame(5'b01001, 5'd0, 4'd0, 6);
    checkValue("rlAfterSrc", 16'(bounceSrc), 16'h09);

    begin
      int sinceSof = 0;
      int period = 10;
      int pauseLeft = 0;
      for (int c = 0; c < 4000; c++) begin
        resetN      = ($urandom_range(0, 799) == 0);
        reset_level = ($urandom_range(0, 299) == 0);
        if (pauseLeft > 0) pauseLeft--;
        else if ($urandom_range(0, 99) == 0) pauseLeft = $urandom_range(1, 30);
        pause = (pauseLeft > 0);
        if (sinceSof >= period) begin
          startOfFrame = 1; sinceSof = 0; period = $urandom_range(2, 20);
        end else begin
          startOfFrame = 0; sinceSof++;
        end
        cTop   = ($urandom_range(0, 5) == 0);
        cLeft  = ($urandom_range(0, 5) == 0);
        cRight = ($urandom_range(0, 5) == 0);
        cFlip  = ($urandom_range(0, 5) == 0);
        cObs   = ($urandom_range(0, 4) == 0);
        hitEdgeCode = 4'($urandom_range(0, 15));
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
